// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

  // IDLE: waiting for an operand pair
  // RUN:  one result bit produced per clock
  // DONE: result held until the consumer takes it
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_cell.sv
// full_subtractor_cell
// One-bit full subtractor, purely combinational: d = a - b - bin.
// Ports:
//   a_i, b_i, bin_i : minuend bit, subtrahend bit, borrow-in
//   d_o, bout_o     : difference bit, borrow-out
module full_subtractor_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  logic eq;

  always_comb begin
    eq     = ~(a_i ^ b_i);
    d_o    = a_i ^ b_i ^ bin_i;
    // Borrow when a<b outright, or when the bits are equal and a borrow comes in.
    bout_o = (~a_i & b_i) | (eq & bin_i);
  end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial WIDTH-bit subtractor: diff = (a - b) mod 2^WIDTH and
// borrow = (a < b), computed LSB first, one bit per clock through a single
// full-subtractor cell and a borrow flip-flop.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE; out_valid is 1 only in DONE. in_valid
// is ignored outside IDLE, and diff/borrow stay stable while out_valid=1.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake, a (minuend), b (subtrahend)
//   out_valid/out_ready : result handshake, diff, borrow
//   state_o           : current FSM state (debug observation)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output state_e           state_o
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_ff_q, borrow_ff_d;
  logic             borrow_q, borrow_d;

  logic cell_d;
  logic cell_bout;

  full_subtractor_cell u_cell (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .bin_i  (borrow_ff_q),
    .d_o    (cell_d),
    .bout_o (cell_bout)
  );

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    d_sr_d      = d_sr_q;
    diff_d      = diff_q;
    cnt_d       = cnt_q;
    borrow_ff_d = borrow_ff_q;
    borrow_d    = borrow_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sr_d      = a;
          b_sr_d      = b;
          borrow_ff_d = 1'b0;
          cnt_d       = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        // New bit enters at the MSB so after WIDTH shifts bit 0 is the LSB result.
        d_sr_d      = {cell_d, d_sr_q[WIDTH-1:1]};
        a_sr_d      = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d      = {1'b0, b_sr_q[WIDTH-1:1]};
        borrow_ff_d = cell_bout;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d   = {cell_d, d_sr_q[WIDTH-1:1]};
          borrow_d = cell_bout;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      d_sr_q      <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      borrow_ff_q <= 1'b0;
      borrow_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      d_sr_q      <= d_sr_d;
      diff_q      <= diff_d;
      cnt_q       <= cnt_d;
      borrow_ff_q <= borrow_ff_d;
      borrow_q    <= borrow_d;
    end
  end

  assign diff    = diff_q;
  assign borrow  = borrow_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W = 8;

  // clock / reset
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  state_e       state_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .state_o   (state_o)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: one full operation with latency check and optional output stall.
  task automatic do_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                       input logic [W-1:0] exp_d, input logic exp_b,
                       input int stall, input string tag);
    int n;
    logic quiet;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    a = a_v;
    b = b_v;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    quiet = 1'b1;
    for (int i = 1; i < W; i++) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b0) quiet = 1'b0;
    end
    chk({tag, ".run_quiet"}, 32'(quiet), 32'd1);
    tick();
    chk({tag, ".out_valid_at_W"}, 32'(out_valid), 32'd1);
    chk({tag, ".diff"}, 32'(diff), 32'(exp_d));
    chk({tag, ".borrow"}, 32'(borrow), 32'(exp_b));
    chk({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    if (stall > 0) begin
      repeat (stall) tick();
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_diff"}, 32'(diff), 32'(exp_d));
      chk({tag, ".hold_borrow"}, 32'(borrow), 32'(exp_b));
      chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst.state", 32'(state_o), 32'(IDLE));
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.diff", 32'(diff), 32'd0);
    chk("rst.borrow", 32'(borrow), 32'd0);
    rst = 1'b0;
    tick();

    // directed vectors, hand-computed results
    do_op(8'h05, 8'h03, 8'h02, 1'b0, 0, "v5m3");
    do_op(8'h03, 8'h05, 8'hFE, 1'b1, 0, "v3m5");
    do_op(8'h00, 8'hFF, 8'h01, 1'b1, 0, "v0mff");
    do_op(8'hFF, 8'hFF, 8'h00, 1'b0, 0, "vffmff");
    do_op(8'hA0, 8'h0F, 8'h91, 1'b0, 5, "bp");
    do_op(8'h00, 8'h01, 8'hFF, 1'b1, 0, "v0m1");
    do_op(8'h80, 8'h7F, 8'h01, 1'b0, 2, "v80m7f");

    // in_valid held high with changing operands: only the first pair counts
    a = 8'h10;
    b = 8'h01;
    in_valid = 1'b1;
    tick();
    for (int i = 0; i < W; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      tick();
    end
    chk("hold.out_valid", 32'(out_valid), 32'd1);
    chk("hold.diff", 32'(diff), 32'h0F);
    chk("hold.borrow", 32'(borrow), 32'd0);
    a = 8'h07;
    b = 8'h09;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold.idle_state", 32'(state_o), 32'(IDLE));
    tick();
    in_valid = 1'b0;
    chk("hold.second_accepted", 32'(state_o), 32'(RUN));
    repeat (W) tick();
    chk("hold.second_valid", 32'(out_valid), 32'd1);
    chk("hold.second_diff", 32'(diff), 32'hFE);
    chk("hold.second_borrow", 32'(borrow), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset in the middle of RUN
    a = 8'h80;
    b = 8'h01;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("mid.in_run", 32'(state_o), 32'(RUN));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid.state", 32'(state_o), 32'(IDLE));
    chk("mid.in_ready", 32'(in_ready), 32'd1);
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.diff", 32'(diff), 32'd0);
    chk("mid.borrow", 32'(borrow), 32'd0);
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (W + 2) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    out_ready = 1'b0;
    chk("mid.no_result", 32'(seen), 32'd0);
    do_op(8'h80, 8'h01, 8'h7F, 1'b0, 0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
